// File: rtl/vme_regbank_n.sv
`default_nettype none
// ============================================================================
// Module   : vme_regbank_n
// Purpose  : VME-side control register bank. NUM_REGS read/write registers of
//            REG_WIDTH bits, selected by a word address, with an optional
//            input pipeline on the write path and an optional output pipeline
//            on the read path. Flags accesses to unmapped addresses.
// Ports    : Clk, Rst          - clock, synchronous active-high reset
//            VMEAddr           - word address shared by read and write
//            VMEWrData         - write data (only low REG_WIDTH bits stored)
//            VMEWrMem/VMERdMem - one-cycle write/read request pulses
//            VMERdData         - read data, zero-extended to 32 bits
//            VMERdDone         - read acknowledge
//            VMEWrDone         - write acknowledge
//            VMEAddrErr        - pulses with the Done of an unmapped access
//            regs_o            - flat view of all register contents
//            wr_strobe_o       - one-hot pulse the cycle after a register load
// Revision : 1.0 - initial release
// ============================================================================
module vme_regbank_n #(
  parameter int NUM_REGS   = 4,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 2,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0,
  parameter int IN_PIPE    = 1,
  parameter int OUT_PIPE   = 1
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [ADDR_WIDTH-1:0]         VMEAddr,
  input  logic [31:0]                   VMEWrData,
  input  logic                          VMEWrMem,
  input  logic                          VMERdMem,
  output logic [31:0]                   VMERdData,
  output logic                          VMERdDone,
  output logic                          VMEWrDone,
  output logic                          VMEAddrErr,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_strobe_o
);

  // --------------------------------------------------------------------------
  // Write request, optionally delayed by one edge
  // --------------------------------------------------------------------------
  logic                  w_wr_req;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [REG_WIDTH-1:0]  w_wr_data;

  generate
    if (IN_PIPE != 0) begin : g_in_pipe
      logic                  r_wr_req;
      logic [ADDR_WIDTH-1:0] r_wr_addr;
      logic [REG_WIDTH-1:0]  r_wr_data;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_wr_req  <= 1'b0;
          r_wr_addr <= '0;
          r_wr_data <= '0;
        end else begin
          r_wr_req  <= VMEWrMem;
          r_wr_addr <= VMEAddr;
          r_wr_data <= VMEWrData[REG_WIDTH-1:0];
        end
      end

      assign w_wr_req  = r_wr_req;
      assign w_wr_addr = r_wr_addr;
      assign w_wr_data = r_wr_data;
    end else begin : g_no_in_pipe
      assign w_wr_req  = VMEWrMem;
      assign w_wr_addr = VMEAddr;
      assign w_wr_data = VMEWrData[REG_WIDTH-1:0];
    end
  endgenerate

  // Upper write-data bits are deliberately discarded.
  generate
    if (REG_WIDTH < 32) begin : g_wdata_unused
      logic w_unused_wdata;
      assign w_unused_wdata = ^VMEWrData[31:REG_WIDTH];
    end
  endgenerate

  // Addresses are widened to 32 bits so the range check also works when
  // 2**ADDR_WIDTH is larger than NUM_REGS.
  logic w_wr_hit;
  assign w_wr_hit = (32'(w_wr_addr) < NUM_REGS);

  // --------------------------------------------------------------------------
  // Register file and per-register write strobes
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0]           w_wr_sel;
  logic [NUM_REGS-1:0]           r_wr_strobe;
  logic [NUM_REGS*REG_WIDTH-1:0] w_regs;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [REG_WIDTH-1:0] r_reg;

      assign w_wr_sel[gi] = w_wr_req && w_wr_hit && (32'(w_wr_addr) == 32'(gi));

      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_reg <= RESET_VALUES[gi*REG_WIDTH +: REG_WIDTH];
        end else if (w_wr_sel[gi]) begin
          r_reg <= w_wr_data;
        end
      end

      assign w_regs[gi*REG_WIDTH +: REG_WIDTH] = r_reg;
    end
  endgenerate

  // Write acknowledge, error and strobe are all set at the commit edge, so
  // they appear together in the following cycle.
  logic r_wr_done;
  logic r_wr_err;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_done   <= 1'b0;
      r_wr_err    <= 1'b0;
      r_wr_strobe <= '0;
    end else begin
      r_wr_done   <= w_wr_req;
      r_wr_err    <= w_wr_req && !w_wr_hit;
      r_wr_strobe <= w_wr_sel;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: live address, current register contents, no write forwarding
  // --------------------------------------------------------------------------
  logic [31:0] w_rd_dat;
  logic        w_rd_err;

  always_comb begin
    w_rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(VMEAddr) == 32'(i)) begin
        w_rd_dat = 32'(w_regs[i*REG_WIDTH +: REG_WIDTH]);
      end
    end
  end

  assign w_rd_err = VMERdMem && !(32'(VMEAddr) < NUM_REGS);

  logic w_rd_err_out;

  generate
    if (OUT_PIPE != 0) begin : g_out_pipe
      logic        r_rd_done;
      logic        r_rd_err;
      logic [31:0] r_rd_data;

      // Data is only loaded on a read so it holds between acknowledges.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_rd_done <= 1'b0;
          r_rd_err  <= 1'b0;
          r_rd_data <= '0;
        end else begin
          r_rd_done <= VMERdMem;
          r_rd_err  <= w_rd_err;
          if (VMERdMem) begin
            r_rd_data <= w_rd_dat;
          end
        end
      end

      assign VMERdDone    = r_rd_done;
      assign VMERdData    = r_rd_data;
      assign w_rd_err_out = r_rd_err;
    end else begin : g_no_out_pipe
      // Data is gated by the request so the bus reads zero when idle.
      assign VMERdDone    = VMERdMem;
      assign VMERdData    = VMERdMem ? w_rd_dat : 32'd0;
      assign w_rd_err_out = w_rd_err;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign VMEWrDone   = r_wr_done;
  assign VMEAddrErr  = r_wr_err | w_rd_err_out;
  assign regs_o      = w_regs;
  assign wr_strobe_o = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_vme_regbank_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_vme_regbank_n
// Purpose  : Self-checking bench for vme_regbank_n. Three builds:
//            A - 4 regs, IN_PIPE=1, OUT_PIPE=1 (table-driven)
//            B - 4 regs, IN_PIPE=0, OUT_PIPE=0
//            C - 3 regs on a 2-bit address, IN_PIPE=1, OUT_PIPE=1
// Revision : 1.0 - initial release
// ============================================================================
module tb_vme_regbank_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT A ----------------
  logic [1:0]  a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [31:0] a_rdata, a_regs;
  logic        a_rdone, a_wdone, a_err;
  logic [3:0]  a_strobe;

  vme_regbank_n #(.NUM_REGS(4), .REG_WIDTH(8), .ADDR_WIDTH(2),
                  .RESET_VALUES(32'h44332211), .IN_PIPE(1), .OUT_PIPE(1)) u_a (
    .Clk(clk), .Rst(rst), .VMEAddr(a_addr), .VMEWrData(a_wdata),
    .VMEWrMem(a_wr), .VMERdMem(a_rd), .VMERdData(a_rdata),
    .VMERdDone(a_rdone), .VMEWrDone(a_wdone), .VMEAddrErr(a_err),
    .regs_o(a_regs), .wr_strobe_o(a_strobe));

  // ---------------- DUT B ----------------
  logic [1:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_wr = 1'b0, b_rd = 1'b0;
  logic [31:0] b_rdata, b_regs;
  logic        b_rdone, b_wdone, b_err;
  logic [3:0]  b_strobe;

  vme_regbank_n #(.NUM_REGS(4), .REG_WIDTH(8), .ADDR_WIDTH(2),
                  .RESET_VALUES(32'h44332211), .IN_PIPE(0), .OUT_PIPE(0)) u_b (
    .Clk(clk), .Rst(rst), .VMEAddr(b_addr), .VMEWrData(b_wdata),
    .VMEWrMem(b_wr), .VMERdMem(b_rd), .VMERdData(b_rdata),
    .VMERdDone(b_rdone), .VMEWrDone(b_wdone), .VMEAddrErr(b_err),
    .regs_o(b_regs), .wr_strobe_o(b_strobe));

  // ---------------- DUT C ----------------
  logic [1:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_wr = 1'b0, c_rd = 1'b0;
  logic [31:0] c_rdata;
  logic [23:0] c_regs;
  logic        c_rdone, c_wdone, c_err;
  logic [2:0]  c_strobe;

  vme_regbank_n #(.NUM_REGS(3), .REG_WIDTH(8), .ADDR_WIDTH(2),
                  .RESET_VALUES(24'h332211), .IN_PIPE(1), .OUT_PIPE(1)) u_c (
    .Clk(clk), .Rst(rst), .VMEAddr(c_addr), .VMEWrData(c_wdata),
    .VMEWrMem(c_wr), .VMERdMem(c_rd), .VMERdData(c_rdata),
    .VMERdDone(c_rdone), .VMEWrDone(c_wdone), .VMEAddrErr(c_err),
    .regs_o(c_regs), .wr_strobe_o(c_strobe));

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 ns later, well away from the edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        wdone;
    logic        rdone;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  strobe;
    logic [31:0] regs;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic wr, logic rd, logic [1:0] addr, logic [31:0] wdata,
                              logic wdone, logic rdone, logic err, logic [31:0] rdata,
                              logic [3:0] strobe, logic [31:0] regs);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.wdone = wdone; v.rdone = rdone; v.err = err; v.rdata = rdata;
    v.strobe = strobe; v.regs = regs;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Inputs for cycle i, then the outputs expected during that cycle.
    //             wr rd ad  wdata           wd rd er rdata          strobe   regs
    vecs[0]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 32'h00000000, 4'b0000, 32'h44332211);
    vecs[1]  = mk(1, 0, 2, 32'hDEADBEA5,   0, 0, 0, 32'h00000000, 4'b0000, 32'h44332211);
    vecs[2]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 32'h00000000, 4'b0000, 32'h44332211);
    vecs[3]  = mk(0, 0, 0, 32'h0,          1, 0, 0, 32'h00000000, 4'b0100, 32'h44A52211);
    vecs[4]  = mk(0, 1, 2, 32'h0,          0, 0, 0, 32'h00000000, 4'b0000, 32'h44A52211);
    vecs[5]  = mk(0, 0, 0, 32'h0,          0, 1, 0, 32'h000000A5, 4'b0000, 32'h44A52211);
    vecs[6]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 32'h000000A5, 4'b0000, 32'h44A52211);
    vecs[7]  = mk(1, 1, 1, 32'h00000077,   0, 0, 0, 32'h000000A5, 4'b0000, 32'h44A52211);
    vecs[8]  = mk(0, 0, 0, 32'h0,          0, 1, 0, 32'h00000022, 4'b0000, 32'h44A52211);
    vecs[9]  = mk(0, 0, 0, 32'h0,          1, 0, 0, 32'h00000022, 4'b0010, 32'h44A57711);
    vecs[10] = mk(0, 1, 1, 32'h0,          0, 0, 0, 32'h00000022, 4'b0000, 32'h44A57711);
    vecs[11] = mk(0, 0, 0, 32'h0,          0, 1, 0, 32'h00000077, 4'b0000, 32'h44A57711);
    vecs[12] = mk(1, 0, 0, 32'hABCD0010,   0, 0, 0, 32'h00000077, 4'b0000, 32'h44A57711);
    vecs[13] = mk(1, 0, 1, 32'h00000121,   0, 0, 0, 32'h00000077, 4'b0000, 32'h44A57711);
    vecs[14] = mk(1, 0, 2, 32'h00000032,   1, 0, 0, 32'h00000077, 4'b0001, 32'h44A57710);
    vecs[15] = mk(1, 0, 3, 32'h00000043,   1, 0, 0, 32'h00000077, 4'b0010, 32'h44A52110);
    vecs[16] = mk(0, 0, 0, 32'h0,          1, 0, 0, 32'h00000077, 4'b0100, 32'h44322110);
    vecs[17] = mk(0, 0, 0, 32'h0,          1, 0, 0, 32'h00000077, 4'b1000, 32'h43322110);
    vecs[18] = mk(0, 0, 0, 32'h0,          0, 0, 0, 32'h00000077, 4'b0000, 32'h43322110);

    rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- DUT A: table ----------------
    for (int i = 0; i < 19; i++) begin
      step();
      rst     = 1'b0;
      a_wr    = vecs[i].wr;
      a_rd    = vecs[i].rd;
      a_addr  = vecs[i].addr;
      a_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("A_v%0d_wrdone", i), 32'(a_wdone),  32'(vecs[i].wdone));
      chk($sformatf("A_v%0d_rddone", i), 32'(a_rdone),  32'(vecs[i].rdone));
      chk($sformatf("A_v%0d_addrerr", i), 32'(a_err),   32'(vecs[i].err));
      chk($sformatf("A_v%0d_rddata", i), a_rdata,       vecs[i].rdata);
      chk($sformatf("A_v%0d_strobe", i), 32'(a_strobe), 32'(vecs[i].strobe));
      chk($sformatf("A_v%0d_regs", i),   a_regs,        vecs[i].regs);
    end

    // ---------------- DUT A: reset aborts an in-flight write ----------------
    step(); a_wr = 1'b1; a_addr = 2'd0; a_wdata = 32'h00000099; #1;
    step(); a_wr = 1'b0; rst = 1'b1; #1;
    chk("A_abort_wrdone_r1", 32'(a_wdone), 32'd0);
    step(); rst = 1'b0; #1;
    chk("A_abort_regs", a_regs, 32'h44332211);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("A_abort_wrdone_%0d", k), 32'(a_wdone), 32'd0);
      chk($sformatf("A_abort_strobe_%0d", k), 32'(a_strobe), 32'd0);
      step();
      #1;
    end
    chk("A_abort_regs_late", a_regs, 32'h44332211);

    // ---------------- DUT B: no pipelines ----------------
    step(); b_wr = 1'b1; b_addr = 2'd2; b_wdata = 32'hDEADBEA5; #1;
    chk("B_c0_wrdone", 32'(b_wdone), 32'd0);
    chk("B_c0_regs", b_regs, 32'h44332211);
    step(); b_wr = 1'b0; b_rd = 1'b1; #1;
    chk("B_c1_wrdone", 32'(b_wdone), 32'd1);
    chk("B_c1_strobe", 32'(b_strobe), 32'h4);
    chk("B_c1_regs", b_regs, 32'h44A52211);
    chk("B_c1_rddone", 32'(b_rdone), 32'd1);
    chk("B_c1_rddata", b_rdata, 32'h000000A5);
    chk("B_c1_addrerr", 32'(b_err), 32'd0);
    step(); b_rd = 1'b0; #1;
    chk("B_c2_wrdone", 32'(b_wdone), 32'd0);
    chk("B_c2_rddone", 32'(b_rdone), 32'd0);

    // ---------------- DUT C: unmapped address 3 ----------------
    step(); c_wr = 1'b1; c_addr = 2'd3; c_wdata = 32'h00000055; #1;
    chk("C_c0_wrdone", 32'(c_wdone), 32'd0);
    step(); c_wr = 1'b0; #1;
    chk("C_c1_wrdone", 32'(c_wdone), 32'd0);
    step(); #1;
    chk("C_c2_wrdone", 32'(c_wdone), 32'd1);
    chk("C_c2_addrerr", 32'(c_err), 32'd1);
    chk("C_c2_strobe", 32'(c_strobe), 32'd0);
    chk("C_c2_regs", 32'(c_regs), 32'h00332211);
    step(); c_rd = 1'b1; c_addr = 2'd1; #1;
    chk("C_c3_wrdone", 32'(c_wdone), 32'd0);
    chk("C_c3_addrerr", 32'(c_err), 32'd0);
    step(); c_addr = 2'd3; #1;
    chk("C_c4_rddone", 32'(c_rdone), 32'd1);
    chk("C_c4_rddata", c_rdata, 32'h00000022);
    chk("C_c4_addrerr", 32'(c_err), 32'd0);
    step(); c_rd = 1'b0; #1;
    chk("C_c5_rddone", 32'(c_rdone), 32'd1);
    chk("C_c5_rddata", c_rdata, 32'h00000000);
    chk("C_c5_addrerr", 32'(c_err), 32'd1);
    step(); #1;
    chk("C_c6_rddone", 32'(c_rdone), 32'd0);
    chk("C_c6_addrerr", 32'(c_err), 32'd0);
    chk("C_c6_regs", 32'(c_regs), 32'h00332211);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vme_regbank_n.md
Name: vme_regbank_n

Overview:
- Parametrised VME-side control register bank: NUM_REGS read/write registers of REG_WIDTH bits each, selected by a word address.
- Optional input pipeline on the write path and optional output pipeline on the read path.
- Per-register write strobes and an unmapped-address flag.
- Sits between the VME slave core and user logic; successor to the single-register bank.

Parameters:
- NUM_REGS, 4, number of registers (1..256).
- REG_WIDTH, 8, bits per register (1..32); read data zero-extended to 32.
- ADDR_WIDTH, 2, word-address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- RESET_VALUES, 0, flat NUM_REGS*REG_WIDTH vector; register i resets to slice [i*REG_WIDTH +: REG_WIDTH].
- IN_PIPE, 1, 1 = register VMEWrMem/VMEWrData/VMEAddr for writes; 0 = use them directly.
- OUT_PIPE, 1, 1 = register read ack/data; 0 = combinational read path.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- VMEAddr  in  ADDR_WIDTH  word address, shared by read and write.
- VMEWrData  in  32  write data.
- VMEWrMem  in  1  write request, one-cycle pulse.
- VMERdMem  in  1  read request, one-cycle pulse.
- VMERdData  out  32  read data.
- VMERdDone  out  1  read acknowledge.
- VMEWrDone  out  1  write acknowledge.
- VMEAddrErr  out  1  pulses with the Done of any access whose address is >= NUM_REGS.
- regs_o  out  NUM_REGS*REG_WIDTH  current register contents, flat.
- wr_strobe_o  out  NUM_REGS  one-hot pulse in the cycle after register i is loaded.

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - Registers take their RESET_VALUES slice.
  - VMERdData = 0.
  - VMERdDone, VMEWrDone, VMEAddrErr and wr_strobe_o = 0.
  - All pipeline stages are cleared, so an in-flight request is dropped and never acknowledged.
- Write path:
  - Request W = (VMEWrMem, VMEWrData, VMEAddr), delayed one edge if IN_PIPE=1.
  - At the edge where W is valid with address a < NUM_REGS: reg[a] <= VMEWrData[REG_WIDTH-1:0]; upper bits are ignored.
  - The wack flop is set at that same edge; VMEWrDone = wack, high for exactly one cycle.
  - wr_strobe_o[a] is asserted in the same cycle as VMEWrDone.
  - Latency from the VMEWrMem edge to VMEWrDone high is IN_PIPE+1 edges.
- Read path:
  - rd_ack = VMERdMem and rd_dat = {zeros, reg[VMEAddr]}, decoded combinationally from current register contents.
  - OUT_PIPE=1: both are registered, so VMERdDone/VMERdData are valid one edge after VMERdMem, for one cycle.
  - OUT_PIPE=0: VMERdDone = VMERdMem in the same cycle.
  - When VMERdDone=0 and OUT_PIPE=1, VMERdData holds its last value.
- Unmapped address (a >= NUM_REGS):
  - Write: acknowledged on normal timing, no register or strobe changes, VMEAddrErr=1 with VMEWrDone.
  - Read: acknowledged, data = 0, VMEAddrErr=1 with VMERdDone.
- Simultaneous read and write:
  - The two paths are independent; both are acknowledged.
  - A read of a register whose write has not yet been committed at that edge returns the old value (no forwarding).
  - With IN_PIPE=1, the read address is the live VMEAddr while the write uses the delayed address.
- Back-to-back writes on consecutive cycles are each committed and acknowledged on consecutive cycles; no request is lost.
- The master must not issue a new request while Rst=1.
- Arithmetic: no carries; only slicing and zero-extension.

Test Plan:
- Reset with defaults (RESET_VALUES = 0x44332211): check regs_o = 0x44332211, VMERdData = 0, all Done/strobe/err outputs 0.
- Write 0xDEADBEA5 to addr 2 (IN_PIPE=1):
  - reg2 = 0xA5 after 2 edges.
  - VMEWrDone and wr_strobe_o = 4'b0100 for one cycle.
  - Other registers unchanged.
- Read addr 2 (OUT_PIPE=1): VMERdDone high one edge later with VMERdData = 0x000000A5. Repeat with OUT_PIPE=0: Done and data valid in the same cycle.
- Build with NUM_REGS=3, ADDR_WIDTH=2, access addr 3:
  - Write: acknowledged with VMEAddrErr=1, no strobe, regs unchanged.
  - Read: returns 0 with VMEAddrErr=1.
- Same cycle, write 0x77 to addr 1 and read addr 1: read returns the old value. A read on the cycle after VMEWrDone returns 0x77.
- Assert Rst one edge after VMEWrMem (IN_PIPE=1): no VMEWrDone ever; register holds its reset value. Back-to-back writes to addrs 0,1,2,3 produce four consecutive Done pulses with the correct strobes.
